// File: rtl/muldiv_pkg.sv
// Shared encodings for the iterative multiply/divide unit.
package muldiv_pkg;
  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;
endpackage

// File: rtl/muldiv_sign_fix.sv
// Applies the result signs to the raw magnitude result held in {hi,lo}.
module muldiv_sign_fix #(
  parameter int WIDTH = 32
) (
  input  logic [2*WIDTH-1:0] raw,
  input  logic               neg_prod,
  input  logic               neg_quot,
  input  logic               neg_rem,
  output logic [WIDTH-1:0]   hi,
  output logic [WIDTH-1:0]   lo
);
  logic [2*WIDTH-1:0] prod_n;
  logic [WIDTH-1:0]   rem_n, quot_n;

  assign prod_n = -raw;
  assign rem_n  = -raw[2*WIDTH-1:WIDTH];
  assign quot_n = -raw[WIDTH-1:0];

  always_comb begin
    hi = raw[2*WIDTH-1:WIDTH];
    lo = raw[WIDTH-1:0];
    if (neg_prod) begin
      {hi, lo} = prod_n;
    end else begin
      if (neg_rem)  hi = rem_n;
      if (neg_quot) lo = quot_n;
    end
  end
endmodule

// File: rtl/muldiv_unit.sv
// Iterative signed/unsigned multiply and restoring divide, one bit per cycle,
// operating on magnitudes with the sign applied in a final FIX cycle.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter  int WIDTH = 32,
  localparam int CNT_W = $clog2(WIDTH+1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_by_zero
);
  state_t             state, state_nxt;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   opnd;
  logic [CNT_W-1:0]   cnt;
  logic               is_div, neg_prod, neg_quot, neg_rem;

  logic               op_div, op_signed, a_neg, b_neg, dz_req, last_iter;
  logic [WIDTH-1:0]   a_abs, b_abs, fix_hi, fix_lo;
  logic [WIDTH:0]     add_sum, rem_shift, rem_diff;

  assign op_div    = (op == OP_DIV) || (op == OP_DIVU);
  assign op_signed = (op == OP_MULT) || (op == OP_DIV);
  assign a_neg     = op_signed & a[WIDTH-1];
  assign b_neg     = op_signed & b[WIDTH-1];
  assign a_abs     = a_neg ? -a : a;
  assign b_abs     = b_neg ? -b : b;
  assign dz_req    = op_div && (b == '0);
  assign last_iter = (cnt == CNT_W'(WIDTH-1));
  assign busy      = (state != IDLE);

  // Multiply: add multiplicand into the upper half on the LSB, then shift right.
  assign add_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
  // Divide: {remainder, quotient} shifts left; the trial subtract decides the bit.
  assign rem_shift = acc[2*WIDTH-1:WIDTH-1];
  assign rem_diff  = rem_shift - {1'b0, opnd};

  muldiv_sign_fix #(.WIDTH(WIDTH)) u_sign_fix (
    .raw      (acc),
    .neg_prod (neg_prod),
    .neg_quot (neg_quot),
    .neg_rem  (neg_rem),
    .hi       (fix_hi),
    .lo       (fix_lo)
  );

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start && !dz_req) state_nxt = CALC;
      CALC:    if (last_iter)        state_nxt = FIX;
      FIX:                           state_nxt = IDLE;
      default:                       state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      acc         <= '0;
      opnd        <= '0;
      cnt         <= '0;
      is_div      <= 1'b0;
      neg_prod    <= 1'b0;
      neg_quot    <= 1'b0;
      neg_rem     <= 1'b0;
      hi          <= '0;
      lo          <= '0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          acc         <= {{WIDTH{1'b0}}, op_div ? a_abs : b_abs};
          opnd        <= op_div ? b_abs : a_abs;
          cnt         <= '0;
          is_div      <= op_div;
          neg_prod    <= !op_div && (a_neg ^ b_neg);
          neg_quot    <= op_div && (a_neg ^ b_neg);
          neg_rem     <= op_div && a_neg;
          div_by_zero <= dz_req;
          done        <= dz_req;
        end
        CALC: begin
          cnt <= cnt + 1'b1;
          if (is_div) begin
            if (rem_diff[WIDTH]) acc <= {rem_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
            else                 acc <= {rem_diff[WIDTH-1:0],  acc[WIDTH-2:0], 1'b1};
          end else begin
            acc <= {add_sum, acc[WIDTH-1:1]};
          end
        end
        FIX: begin
          hi   <= fix_hi;
          lo   <= fix_lo;
          done <= 1'b1;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench: 32-bit and 8-bit instances checked against an
// integer-arithmetic reference model.
module tb_muldiv_unit;
  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    bit          dz;
    int          due;
  } exp_t;

  logic        clk, rst;
  logic        start32, busy32, done32, dbz32;
  logic [1:0]  op32;
  logic [31:0] a32, b32, hi32, lo32;
  logic        start8, busy8, done8, dbz8;
  logic [1:0]  op8;
  logic [7:0]  a8, b8, hi8, lo8;

  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  exp_t q32[$];
  exp_t q8[$];
  logic [31:0] last_hi[2];
  logic [31:0] last_lo[2];

  muldiv_unit #(.WIDTH(32)) dut32 (
    .clk(clk), .rst(rst), .start(start32), .op(op32), .a(a32), .b(b32),
    .busy(busy32), .done(done32), .hi(hi32), .lo(lo32), .div_by_zero(dbz32)
  );

  muldiv_unit #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .op(op8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .hi(hi8), .lo(lo8), .div_by_zero(dbz8)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference: plain integer arithmetic on sign-/zero-extended operands.
  function automatic exp_t model(input int sel, input logic [1:0] o,
                                 input logic [31:0] x, input logic [31:0] y, input int e0);
    exp_t   e;
    int     w;
    longint m, ux, uy, sx, sy, p, q, r, half;
    w    = sel ? 8 : 32;
    m    = (longint'(1) << w) - 1;
    half = longint'(1) << (w - 1);
    ux   = longint'(x) & m;
    uy   = longint'(y) & m;
    sx   = (ux ^ half) - half;
    sy   = (uy ^ half) - half;
    e.dz = 1'b0;
    p = 0; q = 0; r = 0;
    case (o)
      2'b00: p = sx * sy;
      2'b01: p = ux * uy;
      2'b10: if (sy == 0) e.dz = 1'b1; else begin q = sx / sy; r = sx % sy; end
      default: if (uy == 0) e.dz = 1'b1; else begin q = ux / uy; r = ux % uy; end
    endcase
    if (o[1]) p = ((r & m) << w) | (q & m);
    if (e.dz) begin
      e.hi  = last_hi[sel];
      e.lo  = last_lo[sel];
      e.due = e0;
    end else begin
      e.hi  = 32'((p >> w) & m);
      e.lo  = 32'(p & m);
      e.due = e0 + w + 1;
      last_hi[sel] = e.hi;
      last_lo[sel] = e.lo;
    end
    return e;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (done32) begin
      if (q32.size() == 0) begin
        total++; bad++;
        $display("FAIL done32: got unexpected done want none (cycle %0d)", cyc);
      end else begin
        e = q32.pop_front();
        chk("hi32", hi32, e.hi);
        chk("lo32", lo32, e.lo);
        chk("dbz32", dbz32, e.dz);
        chk("done32_cycle", cyc, e.due);
        chk("busy32_at_done", busy32, 0);
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (done8) begin
      if (q8.size() == 0) begin
        total++; bad++;
        $display("FAIL done8: got unexpected done want none (cycle %0d)", cyc);
      end else begin
        e = q8.pop_front();
        chk("hi8", hi8, e.hi[7:0]);
        chk("lo8", lo8, e.lo[7:0]);
        chk("dbz8", dbz8, e.dz);
        chk("done8_cycle", cyc, e.due);
      end
    end
  end

  // Called at a negedge; returns at the negedge after the start edge.
  task automatic issue(input int sel, input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    exp_t e;
    e = model(sel, o, x, y, cyc + 1);
    if (sel != 0) begin
      q8.push_back(e);
      start8 = 1'b1; op8 = o; a8 = x[7:0]; b8 = y[7:0];
    end else begin
      q32.push_back(e);
      start32 = 1'b1; op32 = o; a32 = x; b32 = y;
    end
    @(posedge clk);
    #1;
    start32 = 1'b0; start8 = 1'b0;
    op32 = 2'($urandom); a32 = $urandom; b32 = $urandom;
    op8 = 2'($urandom); a8 = 8'($urandom); b8 = 8'($urandom);
    @(negedge clk);
    if (sel != 0) begin
      chk("busy8_after_start", busy8, !e.dz);
      chk("dbz8_after_start", dbz8, e.dz);
    end else begin
      chk("busy32_after_start", busy32, !e.dz);
      chk("dbz32_after_start", dbz32, e.dz);
    end
  endtask

  task automatic wait_idle(input int sel);
    int n;
    n = 0;
    while (((sel != 0) ? q8.size() : q32.size()) != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      total++; bad++;
      $display("FAIL wait_done: got timeout want done within 200 cycles (sel %0d)", sel);
      q32.delete(); q8.delete();
    end
    @(negedge clk);
  endtask

  task automatic rand_ops(input int sel, input int n);
    logic [1:0]  o;
    logic [31:0] x, y;
    for (int i = 0; i < n; i++) begin
      o = 2'($urandom_range(3));
      x = $urandom;
      y = $urandom;
      case ($urandom_range(7))
        0: y = 0;
        1: begin x = (sel != 0) ? 32'h80 : 32'h8000_0000; y = 32'hFFFF_FFFF; end
        2: y = 32'($urandom_range(9));
        default: ;
      endcase
      issue(sel, o, x, y);
      wait_idle(sel);
    end
  endtask

  initial begin
    exp_t e;
    int   n;
    rst = 1'b0;
    start32 = 1'b0; op32 = '0; a32 = '0; b32 = '0;
    start8  = 1'b0; op8  = '0; a8  = '0; b8  = '0;
    last_hi[0] = '0; last_lo[0] = '0; last_hi[1] = '0; last_lo[1] = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy32, 0);
    chk("rst_done", done32, 0);
    chk("rst_hi", hi32, 0);
    chk("rst_lo", lo32, 0);
    chk("rst_dbz", dbz32, 0);
    rst = 1'b1;
    @(negedge clk);

    // Directed cases
    issue(0, 2'b00, 32'hFFFF_FFFD, 32'h0000_0007); wait_idle(0);
    issue(0, 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF); wait_idle(0);
    issue(0, 2'b10, 32'hFFFF_FFF9, 32'h0000_0002); wait_idle(0);
    issue(0, 2'b10, 32'h8000_0000, 32'hFFFF_FFFF); wait_idle(0);
    issue(0, 2'b11, 32'd100,       32'd7);         wait_idle(0);
    issue(0, 2'b10, 32'd55,        32'd0);         wait_idle(0);
    issue(0, 2'b11, 32'd9,         32'd0);         wait_idle(0);
    issue(0, 2'b00, 32'd6,         32'hFFFF_FFFE); wait_idle(0);

    // Reset at E10 of a multiply aborts it
    issue(0, 2'b00, 32'h1234_5678, 32'h9ABC_DEF0);
    repeat (9) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    q32.delete();
    last_hi[0] = '0; last_lo[0] = '0;
    chk("midrst_busy", busy32, 0);
    chk("midrst_done", done32, 0);
    chk("midrst_hi", hi32, 0);
    chk("midrst_lo", lo32, 0);
    chk("midrst_dbz", dbz32, 0);
    rst = 1'b1;
    repeat (40) @(negedge clk);

    // start pulsed during CALC is ignored
    issue(0, 2'b01, 32'd1000, 32'd3000);
    repeat (5) @(negedge clk);
    start32 = 1'b1; op32 = 2'b11; a32 = 32'd77; b32 = 32'd0;
    @(negedge clk);
    start32 = 1'b0;
    wait_idle(0);

    // start held across the done cycle launches a second operation
    e = model(0, 2'b00, 32'hFFFF_FF00, 32'h0000_0100, cyc + 1);
    q32.push_back(e);
    start32 = 1'b1; op32 = 2'b00; a32 = 32'hFFFF_FF00; b32 = 32'h0000_0100;
    @(posedge clk);
    #1;
    op32 = 2'b10; a32 = 32'hFFFF_FF9C; b32 = 32'd7;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!done32 && n < 100);
    e = model(0, 2'b10, 32'hFFFF_FF9C, 32'd7, cyc + 1);
    q32.push_back(e);
    @(posedge clk);
    #1;
    start32 = 1'b0;
    @(negedge clk);
    chk("b2b_busy", busy32, 1);
    wait_idle(0);

    rand_ops(0, 30);

    // 8-bit instance
    issue(1, 2'b00, 32'h80, 32'h80); wait_idle(1);
    issue(1, 2'b10, 32'h80, 32'hFF); wait_idle(1);
    rand_ops(1, 20);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Parametrised iterative multiply/divide unit; successor to the separate fixed-32-bit mult and div blocks that feed the HI/LO registers.
- Supports signed and unsigned multiply and divide in one datapath, with a start/done handshake and divide-by-zero flagging.
- Sits beside the ALU. Operands come from register-bank outputs A/B; hi/lo feed the HI/LO registers. The control FSM drives start/op and waits on done.

Parameters:
- WIDTH, 32, operand width in bits (≥4); hi/lo are each WIDTH bits.
- CNT_W, $clog2(WIDTH+1), iteration counter width (derived; not overridden).

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  reset, synchronous, active-low
- start  input  1  request a new operation; sampled only in IDLE
- op  input  2  00 MULT (signed), 01 MULTU, 10 DIV (signed), 11 DIVU
- a  input  WIDTH  multiplicand / dividend
- b  input  WIDTH  multiplier / divisor
- busy  output  1  high while an operation is in progress
- done  output  1  one-cycle pulse; result or div_by_zero valid
- hi  output  WIDTH  MULT: product[2W-1:W]; DIV: remainder
- lo  output  WIDTH  MULT: product[W-1:0]; DIV: quotient
- div_by_zero  output  1  set by a divide with b==0; holds until next accepted start

Behaviour:
- Reset (rst==0 at a clock edge): state=IDLE; busy=0, done=0, hi=0, lo=0, div_by_zero=0. Reset mid-operation aborts with no partial result.
- States: IDLE, CALC, FIX.
- IDLE, start=1 at edge E0:
  - Latch op and sign flags; load |a| and |b| (unsigned ops use raw values); clear div_by_zero; counter=0.
  - If op is DIV or DIVU and b==0: stay IDLE, done=1 and div_by_zero=1 for the cycle after E0, busy stays 0, hi/lo unchanged.
  - Otherwise go to CALC with busy=1.
- CALC: one iteration per edge (E1..E_WIDTH), then go to FIX.
  - Multiply: shift-add on a 2*WIDTH accumulator.
  - Divide: restoring division, one quotient bit per cycle.
- FIX (edge E_WIDTH+1):
  - Apply the sign and write hi/lo; done=1 for exactly one cycle; busy=0; return to IDLE.
  - Latency: result visible WIDTH+1 edges after the start edge (33 for WIDTH=32).
- Signed multiply: product negated when the operand signs differ.
- Signed divide:
  - Quotient truncates toward zero; remainder takes the dividend's sign.
  - MIN/−1 yields quotient=MIN, remainder=0; no flag, no trap.
- start while busy is ignored. a/b/op are not required to stay stable after E0.
- start high in the done cycle is accepted, since the state is already IDLE (back-to-back operations).
- hi/lo hold the last result until the next successful FIX. A div-by-zero does not modify them.
- done and div_by_zero are registered outputs; there are no combinational paths from inputs to outputs.

Decomposition:
- Shared package muldiv_pkg holds:
  - op encodings: OP_MULT=2'b00, OP_MULTU=2'b01, OP_DIV=2'b10, OP_DIVU=2'b11
  - state encodings: IDLE, CALC, FIX
- Sub-module muldiv_sign_fix (combinational, WIDTH-parametrised): takes the raw 2*WIDTH result, neg_prod, neg_quot and neg_rem; returns the signed hi/lo.
- Iteration logic stays in muldiv_unit.

Test Plan:
- MULT a=FFFFFFFD (−3), b=00000007 -> done at E33; hi=FFFFFFFF, lo=FFFFFFEB; busy high E0..E32.
- MULTU a=b=FFFFFFFF -> hi=FFFFFFFE, lo=00000001.
- DIV a=FFFFFFF9 (−7), b=2 -> lo=FFFFFFFD, hi=FFFFFFFF. DIVU a=100, b=7 -> lo=14, hi=2. DIV a=80000000, b=FFFFFFFF -> lo=80000000, hi=0.
- DIV b=0 after a prior result hi=2, lo=14 -> done and div_by_zero high the cycle after E0; busy never rises; hi=2, lo=14 unchanged. Next valid start clears div_by_zero.
- Edge cases:
  - rst=0 at E10 of a MULT -> all outputs 0, IDLE, no done.
  - start pulsed during CALC -> ignored.
  - start held high across the done cycle -> second operation begins.
- WIDTH=8 instance, MULT −128×−128 -> hi=40, lo=00, done 9 edges after start.
